// File: rtl/decrypt_core.sv
// Receive-side byte decryption: fixed affine transform over GF(2), p = M*c ^ 0x97.
// One registered stage; dout holds its last value when no byte is presented.
module decrypt_core (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic [7:0] dout,
   output logic       dout_valid
);

   logic [7:0] w_plain;
   logic [7:0] r_dout;
   logic       r_dout_valid;

   always_comb begin
      w_plain[0] = din[2] ^ din[7] ^ 1'b1;
      w_plain[1] = din[0] ^ din[1] ^ din[2] ^ din[7] ^ 1'b1;
      w_plain[2] = din[2] ^ din[3] ^ din[5] ^ din[7] ^ 1'b1;
      w_plain[3] = din[0] ^ din[7];
      w_plain[4] = din[0] ^ din[4] ^ din[6] ^ din[7] ^ 1'b1;
      w_plain[5] = din[2] ^ din[3];
      w_plain[6] = din[0] ^ din[2] ^ din[6];
      w_plain[7] = din[6] ^ din[7] ^ 1'b1;
   end

   // dout only loads on a valid beat, so an undriven din between beats never reaches it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout       <= 8'h00;
         r_dout_valid <= 1'b0;
      end else begin
         r_dout_valid <= din_valid;
         if (din_valid) begin
            r_dout <= w_plain;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_decrypt_core.sv
// Scoreboard bench for decrypt_core: expected bytes queued at drive time, popped one cycle later.
module tb_decrypt_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic       din_valid;
   logic [7:0] dout;
   logic       dout_valid;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] sb[$];
   bit         seen[256];
   int         n_distinct;

   decrypt_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   always #5 clk = ~clk;

   // reference built from the column form of M, independent of the per-bit equations
   function automatic logic [7:0] ref_decrypt(input logic [7:0] c);
      logic [7:0] cols [8];
      logic [7:0] p;
      cols = '{8'h5A, 8'h02, 8'h67, 8'h24, 8'h10, 8'h04, 8'hD0, 8'h9F};
      p = 8'h97;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) p = p ^ cols[i];
      end
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag);
      if (dout_valid) begin
         if (sb.size() == 0) chk({tag, "_spurious_valid"}, 32'd1, 32'd0);
         else                chk(tag, {24'd0, dout}, {24'd0, sb.pop_front()});
      end else if (sb.size() != 0) begin
         chk({tag, "_missing_valid"}, 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   task automatic step(input string tag, input bit v, input logic [7:0] d, input logic [7:0] e);
      din_valid = v;
      din       = d;
      if (v) sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] vin  [6];
      logic [7:0] vout [6];
      vin  = '{8'h6C, 8'h9D, 8'h62, 8'h65, 8'h3A, 8'h3B};
      vout = '{8'h00, 8'h01, 8'h41, 8'h7E, 8'hA5, 8'hFF};

      rst_n = 1'b0;
      din = 8'h00;
      din_valid = 1'b0;
      #12;
      chk("reset_dout", {24'd0, dout}, 32'h00);
      chk("reset_valid", {31'd0, dout_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed, one at a time with idle cycles between
      for (int i = 0; i < 6; i++) begin
         step("directed", 1'b1, vin[i], vout[i]);
         step("directed_idle", 1'b0, 8'h00, 8'h00);
      end

      // streaming back-to-back
      for (int i = 0; i < 6; i++) begin
         step("stream", 1'b1, vin[i], vout[i]);
         chk("stream_valid", {31'd0, dout_valid}, 32'd1);
      end

      // hold: din toggles with valid low, dout must keep A5
      step("hold_load", 1'b1, 8'h3A, 8'hA5);
      step("hold", 1'b0, 8'hC5, 8'h00);
      chk("hold_dout", {24'd0, dout}, 32'hA5);
      chk("hold_valid", {31'd0, dout_valid}, 32'd0);
      step("hold2", 1'b0, 8'h5C, 8'h00);
      chk("hold_dout2", {24'd0, dout}, 32'hA5);

      // exhaustive sweep: values and distinctness
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      for (int i = 0; i < 256; i++) begin
         step("sweep", 1'b1, 8'(i), ref_decrypt(8'(i)));
         seen[dout] = 1'b1;
      end
      n_distinct = 0;
      for (int i = 0; i < 256; i++) if (seen[i]) n_distinct++;
      chk("sweep_distinct", n_distinct, 32'd256);

      // async reset mid-cycle while dout_valid is high
      step("pre_reset", 1'b1, 8'h3B, 8'hFF);
      chk("pre_reset_valid", {31'd0, dout_valid}, 32'd1);
      din_valid = 1'b1;
      din = 8'h9D;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_dout", {24'd0, dout}, 32'h00);
      chk("async_rst_valid", {31'd0, dout_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_held_valid", {31'd0, dout_valid}, 32'd0);
      chk("rst_held_dout", {24'd0, dout}, 32'h00);
      sb.delete();
      #2;
      rst_n = 1'b1;

      // first beat after reset release, with an idle cycle in front
      step("post_rst_idle", 1'b0, 8'h9D, 8'h00);
      chk("post_rst_idle_valid", {31'd0, dout_valid}, 32'd0);
      step("post_rst_first", 1'b1, 8'h62, 8'h41);
      chk("post_rst_first_valid", {31'd0, dout_valid}, 32'd1);
      step("post_rst_next", 1'b1, 8'h65, 8'h7E);
      step("drain", 1'b0, 8'h00, 8'h00);
      chk("drain_valid", {31'd0, dout_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
